// File: rtl/edge_event_scheduler.sv
// Rising-edge capture on N level inputs, queued as pending events and drained
// through one valid/ready port with round-robin arbitration.
module edge_event_scheduler #(
   parameter  int N     = 4,
   parameter  int CNT_W = 8,
   localparam int ID_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     a,
   input  logic             enable,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_id,
   output logic [N-1:0]     pending,
   output logic [CNT_W-1:0] overflow_cnt
);

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [N-1:0]      a_reg;
   logic [N-1:0]      pending_reg, pending_next;
   logic [N-1:0]      rise, clr, lost;
   logic              out_valid_reg, out_valid_next;
   logic [ID_W-1:0]   out_id_reg, out_id_next;
   logic [ID_W-1:0]   last_grant_reg, last_grant_next;
   logic [ID_W-1:0]   pick;
   logic              pick_found;
   logic [ID_W:0]     cand;
   logic [ID_W:0]     lost_cnt;
   logic [CNT_W+ID_W:0] ovf_sum;
   logic [CNT_W-1:0]  ovf_reg, ovf_next;

   // A rise that coincides with the handshake of the same channel re-arms it
   // instead of counting as lost.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign rise[gi]         = a[gi] & ~a_reg[gi];
         assign clr[gi]          = out_valid_reg & out_ready & (out_id_reg == ID_W'(gi));
         assign lost[gi]         = rise[gi] & pending_reg[gi] & ~clr[gi];
         assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
      end
   endgenerate

   always_comb begin
      lost_cnt = '0;
      for (int i = 0; i < N; i++) begin
         lost_cnt = lost_cnt + (ID_W+1)'(lost[i]);
      end
      ovf_sum = (CNT_W+ID_W+1)'(ovf_reg) + (CNT_W+ID_W+1)'(lost_cnt);
      if (ovf_sum > (CNT_W+ID_W+1)'({CNT_W{1'b1}})) begin
         ovf_next = '1;
      end else begin
         ovf_next = ovf_sum[CNT_W-1:0];
      end
   end

   // Scan last_grant+1, +2, ... modulo N over the registered pending flags.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      cand       = '0;
      for (int k = 1; k <= N; k++) begin
         cand = {1'b0, last_grant_reg} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N)) begin
            cand = cand - (ID_W+1)'(N);
         end
         if (!pick_found && pending_reg[cand[ID_W-1:0]]) begin
            pick       = cand[ID_W-1:0];
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      out_valid_next  = out_valid_reg;
      out_id_next     = out_id_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            out_valid_next = 1'b0;
            if (enable && pick_found) begin
               out_id_next    = pick;
               out_valid_next = 1'b1;
               state_next     = OFFER;
            end
         end
         OFFER: begin
            if (out_ready) begin
               last_grant_next = out_id_reg;
               out_valid_next  = 1'b0;
               state_next      = IDLE;
            end
         end
         default: begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         a_reg          <= '0;
         pending_reg    <= '0;
         out_valid_reg  <= 1'b0;
         out_id_reg     <= '0;
         last_grant_reg <= ID_W'(N - 1);
         ovf_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         a_reg          <= a;
         pending_reg    <= pending_next;
         out_valid_reg  <= out_valid_next;
         out_id_reg     <= out_id_next;
         last_grant_reg <= last_grant_next;
         ovf_reg        <= ovf_next;
      end
   end

   assign out_valid    = out_valid_reg;
   assign out_id       = out_id_reg;
   assign pending      = pending_reg;
   assign overflow_cnt = ovf_reg;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler (N=4, CNT_W=8): vector table for the
// basic drain sequences, hand-written sequences for the multi-cycle corners.
module tb_edge_event_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic       enable;
   logic       out_ready;
   logic       out_valid;
   logic [1:0] out_id;
   logic [3:0] pending;
   logic [7:0] overflow_cnt;

   int checks = 0;
   int errors = 0;

   edge_event_scheduler #(.N(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .a            (a),
      .enable       (enable),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_id       (out_id),
      .pending      (pending),
      .overflow_cnt (overflow_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] a;
      logic       en;
      logic       rdy;
      logic       ev;
      logic [1:0] eid;
      logic [3:0] ep;
      logic [7:0] eovf;
   } vec_t;

   vec_t vecs [14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // out_id is only compared while an offer is expected
   task automatic check_all(input string tag, input logic ev, input logic [1:0] eid,
                            input logic [3:0] ep, input logic [7:0] eovf);
      check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
      if (ev) check({tag, " out_id"}, 32'(out_id), 32'(eid));
      check({tag, " pending"}, 32'(pending), 32'(ep));
      check({tag, " overflow_cnt"}, 32'(overflow_cnt), 32'(eovf));
      $display("%s: a=%b en=%b rdy=%b valid=%b id=%0d pending=%b ovf=%0d",
               tag, a, enable, out_ready, out_valid, out_id, pending, overflow_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //              a        en    rdy   ev    eid   ep       eovf
      vecs[0]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0};
      vecs[1]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1111, 8'd0};
      vecs[2]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1111, 8'd0};
      vecs[3]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1110, 8'd0};
      vecs[4]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1110, 8'd0};
      vecs[5]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1100, 8'd0};
      vecs[6]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1100, 8'd0};
      vecs[7]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 8'd0};
      vecs[8]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 8'd0};
      vecs[9]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0};
      vecs[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0};
      vecs[11] = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 8'd0};
      vecs[12] = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'd0};
      vecs[13] = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0};

      rst = 1'b0; a = 4'b0000; enable = 1'b1; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_id", 32'(out_id), 32'd0);
      check_all("reset", 1'b0, 2'd0, 4'b0000, 8'd0);
      rst = 1'b1;

      // All four rise at once, then a single rise on ch0
      for (int i = 0; i < 14; i++) begin
         a = vecs[i].a; enable = vecs[i].en; out_ready = vecs[i].rdy;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].ep, vecs[i].eovf);
      end

      // Stalled offer on ch2 with two colliding rises
      a = 4'b0000; out_ready = 1'b0; step();
      a = 4'b0100; step();  check_all("stall rise", 1'b0, 2'd0, 4'b0100, 8'd0);
      step();               check_all("stall offer", 1'b1, 2'd2, 4'b0100, 8'd0);
      a = 4'b0000; step();  check_all("stall c1", 1'b1, 2'd2, 4'b0100, 8'd0);
      a = 4'b0100; step();  check_all("stall c2", 1'b1, 2'd2, 4'b0100, 8'd1);
      a = 4'b0000; step();  check_all("stall c3", 1'b1, 2'd2, 4'b0100, 8'd1);
      a = 4'b0100; step();  check_all("stall c4", 1'b1, 2'd2, 4'b0100, 8'd2);
      a = 4'b0000; step();  check_all("stall c5", 1'b1, 2'd2, 4'b0100, 8'd2);
      step();               check_all("stall c6", 1'b1, 2'd2, 4'b0100, 8'd2);
      out_ready = 1'b1; step(); check_all("stall hs", 1'b0, 2'd0, 4'b0000, 8'd2);
      step();               check_all("stall after1", 1'b0, 2'd0, 4'b0000, 8'd2);
      step();               check_all("stall after2", 1'b0, 2'd0, 4'b0000, 8'd2);

      // Rise on ch1 in its own accept cycle; last_grant is 2 here
      out_ready = 1'b0;
      a = 4'b0010; step();  check_all("same rise", 1'b0, 2'd0, 4'b0010, 8'd2);
      a = 4'b0000; step();  check_all("same offer1", 1'b1, 2'd1, 4'b0010, 8'd2);
      a = 4'b1000; step();  check_all("same ch3", 1'b1, 2'd1, 4'b1010, 8'd2);
      a = 4'b1010; out_ready = 1'b1; step();
      check_all("same hs", 1'b0, 2'd0, 4'b1010, 8'd2);
      out_ready = 1'b0; step(); check_all("same offer3", 1'b1, 2'd3, 4'b1010, 8'd2);
      out_ready = 1'b1; step(); check_all("same hs3", 1'b0, 2'd0, 4'b0010, 8'd2);
      step();               check_all("same reoffer1", 1'b1, 2'd1, 4'b0010, 8'd2);
      step();               check_all("same hs1", 1'b0, 2'd0, 4'b0000, 8'd2);

      // 300 collisions on ch3 while its offer stalls; counter starts at 2
      out_ready = 1'b0; a = 4'b0000; step();
      for (int k = 0; k <= 300; k++) begin
         a = 4'b1000; step();
         a = 4'b0000; step();
         if (k == 100) check("ovf k100", 32'(overflow_cnt), 32'd102);
         if (k == 252) check("ovf k252", 32'(overflow_cnt), 32'd254);
         if (k == 253) check("ovf k253", 32'(overflow_cnt), 32'd255);
      end
      check_all("sat end", 1'b1, 2'd3, 4'b1000, 8'd255);
      enable = 1'b0; out_ready = 1'b1; step();
      check_all("sat hs", 1'b0, 2'd0, 4'b0000, 8'd255);
      a = 4'b0110; step();  check_all("dis rise", 1'b0, 2'd0, 4'b0110, 8'd255);
      for (int k = 0; k < 3; k++) begin
         step(); check_all($sformatf("dis hold%0d", k), 1'b0, 2'd0, 4'b0110, 8'd255);
      end
      enable = 1'b1; step(); check_all("en offer1", 1'b1, 2'd1, 4'b0110, 8'd255);
      step();               check_all("en hs1", 1'b0, 2'd0, 4'b0100, 8'd255);
      step();               check_all("en offer2", 1'b1, 2'd2, 4'b0100, 8'd255);
      step();               check_all("en hs2", 1'b0, 2'd0, 4'b0000, 8'd255);

      // Asynchronous reset during an offer, a=0100 held across release
      out_ready = 1'b0; a = 4'b0000; step();
      a = 4'b0100; step();  check_all("rst rise", 1'b0, 2'd0, 4'b0100, 8'd255);
      step();               check_all("rst offer", 1'b1, 2'd2, 4'b0100, 8'd255);
      #2;
      rst = 1'b0;
      #1;
      check_all("rst async", 1'b0, 2'd0, 4'b0000, 8'd0);
      step();               check_all("rst held", 1'b0, 2'd0, 4'b0000, 8'd0);
      rst = 1'b1;
      step();               check_all("rel rise", 1'b0, 2'd0, 4'b0100, 8'd0);
      step();               check_all("rel offer", 1'b1, 2'd2, 4'b0100, 8'd0);
      out_ready = 1'b1; step(); check_all("rel hs", 1'b0, 2'd0, 4'b0000, 8'd0);
      step();               check_all("rel idle1", 1'b0, 2'd0, 4'b0000, 8'd0);
      step();               check_all("rel idle2", 1'b0, 2'd0, 4'b0000, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
